// File: rtl/pdu_ring_writer_if.sv
// Bundle of the flit-in stream, the ring write port and the batch commit
// signals around pdu_ring_writer. The slave modport is the writer itself.
//
// Handshake: a flit moves on a rising clk edge where in_valid and in_ready
// are both high; in_ready never depends on in_valid; a source holding
// in_valid keeps in_data/in_sop/in_eop/in_empty stable until the transfer.
// wr_en and update_valid are single-cycle strobes with no back-pressure.
interface pdu_ring_writer_if #(
    parameter int PDU_AWIDTH = 12
);
    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } flit_lite_t;

    // Flit input stream
    logic [511:0]          in_data;
    logic                  in_valid;
    logic                  in_sop;
    logic                  in_eop;
    logic [5:0]            in_empty;
    logic                  in_ready;

    // Ring buffer write side
    flit_lite_t            wr_data;
    logic [PDU_AWIDTH-1:0] wr_addr;
    logic                  wr_en;
    logic [PDU_AWIDTH-1:0] wr_base_addr;
    logic                  almost_full;

    // Batch commit towards the DMA engine
    logic                  update_valid;
    logic [PDU_AWIDTH-1:0] update_size;

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty,
        input  in_ready,
        input  wr_data, wr_addr, wr_en,
        output wr_base_addr, almost_full,
        input  update_valid, update_size
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty,
        output in_ready,
        output wr_data, wr_addr, wr_en,
        input  wr_base_addr, almost_full,
        output update_valid, update_size
    );
endinterface

// File: rtl/pdu_ring_writer.sv
// Writes admitted packets into the FPGA-side ring at wr_base_addr + pending,
// drops malformed/oversize/aborted packets by rewinding pending to the packet
// start, and commits coalesced batches with a one-cycle update strobe.
// Parameters must satisfy BATCH_FLITS + MAX_PDU_FLITS - 1 < 2**PDU_AWIDTH.
module pdu_ring_writer #(
    parameter int PDU_AWIDTH     = 12,
    parameter int MAX_PDU_FLITS  = 24,
    parameter int BATCH_FLITS    = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    pdu_ring_writer_if.slave  bus,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       drop_cnt,
    output logic [1:0]        dbg_state_o
);
    localparam int FLIT_W = 520;
    localparam int TW     = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PKT    = 2'd1,
        S_FLUSH  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PDU_AWIDTH-1:0] pending_q, pending_d;
    logic [PDU_AWIDTH-1:0] pkt_start_q, pkt_start_d;
    logic                  dropping_q, dropping_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  wr_en_q, wr_en_d;
    logic [PDU_AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [FLIT_W-1:0]     wr_data_q, wr_data_d;
    logic                  upd_valid_q, upd_valid_d;
    logic [PDU_AWIDTH-1:0] upd_size_q, upd_size_d;
    logic [31:0]           pkt_cnt_q, pkt_cnt_d;
    logic [31:0]           drop_cnt_q, drop_cnt_d;

    logic                  in_ready;
    logic                  accept;
    logic [FLIT_W-1:0]     in_flit;
    logic [PDU_AWIDTH-1:0] pkt_len;
    logic                  at_max;

    assign in_flit = {bus.in_data, bus.in_sop, bus.in_eop, bus.in_empty};
    assign accept  = bus.in_valid & in_ready;
    assign pkt_len = pending_q - pkt_start_q;
    assign at_max  = (pkt_len == PDU_AWIDTH'(MAX_PDU_FLITS));

    // Ready depends only on state and almost_full; forced low while in reset
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = ~bus.almost_full;
            S_PKT:   in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
        in_ready = in_ready & rst_n;
    end

    assign bus.in_ready     = in_ready;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.update_valid = upd_valid_q;
    assign bus.update_size  = upd_size_q;
    assign pkt_cnt          = pkt_cnt_q;
    assign drop_cnt         = drop_cnt_q;
    assign dbg_state_o      = state_q;

    // Next-state and registered-output computation for the writer FSM
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pkt_start_d = pkt_start_q;
        dropping_d  = dropping_q;
        timer_d     = timer_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        upd_valid_d = 1'b0;
        upd_size_d  = upd_size_q;
        pkt_cnt_d   = pkt_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    timer_d     = '0;
                    pkt_start_d = pending_q;
                    if (bus.in_sop) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = bus.wr_base_addr + pending_q;
                        wr_data_d = in_flit;
                        pending_d = pending_q + 1'b1;
                        if (bus.in_eop) begin
                            pkt_cnt_d = pkt_cnt_q + 32'd1;
                            state_d   = (pending_d >= PDU_AWIDTH'(BATCH_FLITS)) ? S_FLUSH : S_IDLE;
                        end else begin
                            state_d = S_PKT;
                        end
                    end else if (bus.in_eop) begin
                        // Lone headless flit: nothing written, count the drop now
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end else begin
                        dropping_d = 1'b1;
                        state_d    = S_PKT;
                    end
                end else if (pending_q != '0) begin
                    // A partial batch must leave when the ring is tight or traffic stalls
                    if (bus.almost_full || (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
                        state_d = S_FLUSH;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end

            S_PKT: begin
                timer_d = '0;
                if (accept) begin
                    if (bus.in_sop) begin
                        // Abort the open packet and restart at its start slot
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        dropping_d = 1'b0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = bus.wr_base_addr + pkt_start_q;
                        wr_data_d  = in_flit;
                        pending_d  = pkt_start_q + 1'b1;
                        if (bus.in_eop) begin
                            pkt_cnt_d = pkt_cnt_q + 32'd1;
                            state_d   = (pending_d >= PDU_AWIDTH'(BATCH_FLITS)) ? S_FLUSH : S_IDLE;
                        end
                    end else if (dropping_q || at_max) begin
                        // Malformed or oversize: swallow flits, rewind at EOP
                        dropping_d = 1'b1;
                        if (bus.in_eop) begin
                            pending_d  = pkt_start_q;
                            drop_cnt_d = drop_cnt_q + 32'd1;
                            dropping_d = 1'b0;
                            state_d    = (pkt_start_q >= PDU_AWIDTH'(BATCH_FLITS)) ? S_FLUSH : S_IDLE;
                        end
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = bus.wr_base_addr + pending_q;
                        wr_data_d = in_flit;
                        pending_d = pending_q + 1'b1;
                        if (bus.in_eop) begin
                            pkt_cnt_d = pkt_cnt_q + 32'd1;
                            state_d   = (pending_d >= PDU_AWIDTH'(BATCH_FLITS)) ? S_FLUSH : S_IDLE;
                        end
                    end
                end
            end

            S_FLUSH: begin
                // An empty batch (everything dropped) commits nothing
                if (pending_q != '0) begin
                    upd_valid_d = 1'b1;
                    upd_size_d  = pending_q;
                    state_d     = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
                pending_d   = '0;
                pkt_start_d = '0;
                timer_d     = '0;
                dropping_d  = 1'b0;
            end

            S_SETTLE: begin
                // Gives the ring one cycle to move wr_base_addr past the batch
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any partially written packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            pkt_start_q <= '0;
            dropping_q  <= 1'b0;
            timer_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            upd_valid_q <= 1'b0;
            upd_size_q  <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pkt_start_q <= pkt_start_d;
            dropping_q  <= dropping_d;
            timer_q     <= timer_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            upd_valid_q <= upd_valid_d;
            upd_size_q  <= upd_size_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_pdu_ring_writer.sv
// Bench for pdu_ring_writer: a reference model predicts every ring write and
// batch commit (with its cycle), a negedge monitor pops and compares them.
module tb_pdu_ring_writer;
    localparam int AW    = 12;
    localparam int MAXF  = 24;
    localparam int BATCH = 32;
    localparam int TMO   = 256;
    localparam int FW    = 520;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;
    logic [1:0]  dbg_state;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    // Expected ring writes {addr, data, sop, eop, empty} and commits {size, cycle}
    logic [AW+FW-1:0] exp_wr_q[$];
    logic [AW+32-1:0] exp_upd_q[$];

    // Reference model state
    int m_pending = 0;
    int m_last_acc = 0;
    bit m_open = 1'b0;

    typedef struct {
        int len;
        bit sop_ok;
        bit has_eop;
        int exp_pkt;
        int exp_drop;
    } vec_t;
    vec_t vecs[8];

    pdu_ring_writer_if #(.PDU_AWIDTH(AW)) bus();

    pdu_ring_writer #(
        .PDU_AWIDTH(AW), .MAX_PDU_FLITS(MAXF), .BATCH_FLITS(BATCH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .dbg_state_o(dbg_state)
    );

    // Clock and cycle index (cyc = number of rising edges so far)
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        logic [AW+FW-1:0] got;
        logic [AW+FW-1:0] e;
        logic [AW+32-1:0] ue;
        if (bus.wr_en === 1'b1) begin
            got = {bus.wr_addr, bus.wr_data};
            total++;
            if (exp_wr_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr %0h, expected no write", bus.wr_addr);
            end else begin
                e = exp_wr_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL ring_write: got %0h expected %0h", got, e);
                end
            end
        end
        if (bus.update_valid === 1'b1) begin
            check("update_with_wr_en", 64'(bus.wr_en), 64'd0);
            if (exp_upd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_update: got size %0d, expected no update", bus.update_size);
            end else begin
                ue = exp_upd_q.pop_front();
                check("update_size", 64'(bus.update_size), 64'(ue[AW+31:32]));
                check("update_cycle", 64'(cyc), 64'(ue[31:0]));
            end
        end
    endtask

    // Drive one flit and wait (bounded) for it to be accepted; acc = edge index
    task automatic send_flit(input logic sop, input logic eop, input logic [511:0] d,
                             input logic [5:0] emp, output int acc);
        int budget;
        budget = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        bus.in_data  = d;
        bus.in_empty = emp;
        #1;
        while (bus.in_ready !== 1'b1 && budget < 2000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (bus.in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_wait: got in_ready=0 for %0d cycles, expected 1", budget);
            bus.in_valid = 1'b0;
            acc = cyc;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            bus.in_valid = 1'b0;
        end
    endtask

    // Send a packet and predict its writes, counters and any threshold commit
    task automatic send_pkt(input int len, input bit sop_ok, input bit has_eop);
        int start;
        int acc;
        logic [31:0] r;
        logic [511:0] d;
        logic [5:0] emp;
        logic sop;
        logic eop;
        logic [AW-1:0] a;
        start = m_pending;
        for (int i = 0; i < len; i++) begin
            r   = $urandom();
            d   = {16{r}};
            sop = sop_ok && (i == 0);
            eop = has_eop && (i == len - 1);
            emp = eop ? 6'($urandom_range(0, 63)) : 6'd0;
            if (sop_ok && i < MAXF) begin
                a = bus.wr_base_addr + AW'(start + i);
                exp_wr_q.push_back({a, d, sop, eop, emp});
            end
            send_flit(sop, eop, d, emp, acc);
            m_last_acc = acc;
        end
        m_open = !has_eop && sop_ok;
        if (has_eop) begin
            if (sop_ok && len <= MAXF) m_pending = start + len;
            if (m_pending >= BATCH) begin
                exp_upd_q.push_back({AW'(m_pending), 32'(m_last_acc + 1)});
                m_pending = 0;
            end
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_wr_q.size() != 0 || exp_upd_q.size() != 0) && budget < TMO + 100) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        check("queues_drained", 64'(exp_wr_q.size() + exp_upd_q.size()), 64'd0);
    endtask

    // With no further traffic the pending batch leaves TMO+1 edges after the last accept
    task automatic expect_timeout_flush();
        if (m_pending > 0) begin
            exp_upd_q.push_back({AW'(m_pending), 32'(m_last_acc + TMO + 1)});
            m_pending = 0;
        end
        drain();
    endtask

    initial begin
        int acc;
        int w;
        logic [511:0] d;

        vecs[0] = '{8,  1'b1, 1'b1, 8,  1};
        vecs[1] = '{1,  1'b1, 1'b1, 9,  1};
        vecs[2] = '{3,  1'b0, 1'b1, 9,  2};
        vecs[3] = '{24, 1'b1, 1'b1, 10, 2};
        vecs[4] = '{25, 1'b1, 1'b1, 10, 3};
        vecs[5] = '{2,  1'b1, 1'b0, 10, 3};
        vecs[6] = '{4,  1'b1, 1'b1, 11, 4};
        vecs[7] = '{1,  1'b0, 1'b1, 11, 5};

        bus.in_valid = 1'b0;
        bus.in_sop = 1'b0;
        bus.in_eop = 1'b0;
        bus.in_data = '0;
        bus.in_empty = '0;
        bus.wr_base_addr = '0;
        bus.almost_full = 1'b0;
        rst_n = 1'b1;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_update_valid", 64'(bus.update_valid), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_update_size", 64'(bus.update_size), 64'd0);
        check("rst_wr_data_or", 64'(|bus.wr_data), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(bus.in_ready), 64'd1);

        // Single 3-flit packet at 0x10, committed by the idle timeout
        bus.wr_base_addr = 12'h010;
        send_pkt(3, 1'b1, 1'b1);
        expect_timeout_flush();
        check("single_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Four back-to-back 8-flit packets reach the batch threshold
        bus.wr_base_addr = 12'h040;
        for (int i = 0; i < 4; i++) send_pkt(8, 1'b1, 1'b1);
        @(negedge clk);
        check("thr_ready_flush", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("thr_ready_settle", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("thr_ready_back", 64'(bus.in_ready), 64'd1);
        drain();
        check("thr_pkt_cnt", 64'(pkt_cnt), 64'd5);

        // Ring wrap: addresses FFE, FFF, 000, 001
        bus.wr_base_addr = 12'hFFE;
        send_pkt(4, 1'b1, 1'b1);
        expect_timeout_flush();

        // Oversize packet is rewound; the following packet reuses its slots
        bus.wr_base_addr = 12'h300;
        send_pkt(30, 1'b1, 1'b1);
        check("oversize_drop_cnt", 64'(drop_cnt), 64'd1);
        send_pkt(2, 1'b1, 1'b1);
        expect_timeout_flush();
        check("oversize_pkt_cnt", 64'(pkt_cnt), 64'd7);

        // Table of mixed packets: exact max, malformed, oversize, abort by SOP
        bus.wr_base_addr = 12'h200;
        for (int i = 0; i < 8; i++) begin
            send_pkt(vecs[i].len, vecs[i].sop_ok, vecs[i].has_eop);
            check($sformatf("vec%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(vecs[i].exp_pkt));
            check($sformatf("vec%0d_drop_cnt", i), 64'(drop_cnt), 64'(vecs[i].exp_drop));
        end
        expect_timeout_flush();

        // almost_full with 5 flits pending forces an immediate flush
        bus.wr_base_addr = 12'h500;
        send_pkt(5, 1'b1, 1'b1);
        @(negedge clk);
        bus.almost_full = 1'b1;
        w = cyc;
        exp_upd_q.push_back({AW'(5), 32'(w + 2)});
        m_pending = 0;
        bus.in_valid = 1'b1;
        bus.in_sop = 1'b1;
        bus.in_eop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("af_ready_low", 64'(bus.in_ready), 64'd0);
            if (i == 1) check("af_flush_state", 64'(dbg_state), 64'd2);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.almost_full = 1'b0;
        drain();
        check("af_pkt_cnt", 64'(pkt_cnt), 64'd12);

        // Asynchronous reset in the middle of a packet
        bus.wr_base_addr = 12'h600;
        for (int i = 0; i < 3; i++) begin
            d = {16{$urandom()}};
            exp_wr_q.push_back({AW'(12'h600 + i), d, (i == 0), 1'b0, 6'd0});
            send_flit(i == 0, 1'b0, d, 6'd0, acc);
        end
        drain();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(bus.in_ready), 64'd0);
        check("arst_wr_en", 64'(bus.wr_en), 64'd0);
        check("arst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("arst_wr_data_or", 64'(|bus.wr_data), 64'd0);
        check("arst_update_valid", 64'(bus.update_valid), 64'd0);
        check("arst_update_size", 64'(bus.update_size), 64'd0);
        check("arst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("arst_state", 64'(dbg_state), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_pending = 0;
        m_open = 1'b0;
        repeat (TMO + 40) @(negedge clk);
        check("post_reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("post_reset_queues", 64'(exp_wr_q.size() + exp_upd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
